// File: rtl/game_pkg.sv
// Shared encodings and screen geometry for the Flappy Bird design.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DEAD = 2'd2,
        ST_OVER = 2'd3
    } game_state_e;

    localparam int unsigned SCREEN_W   = 640;
    localparam int unsigned SCREEN_H   = 480;
    localparam int unsigned BIRD_POS_X = 100;
    localparam int unsigned BIRD_SIZE  = 40;
    localparam int unsigned PIPE_W     = 40;
    localparam int unsigned GAP_HALF   = 70;

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for the asynchronous button plus a one-clk rising-edge pulse.
module btn_sync (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_rise
);

    logic sync1_q, sync2_q, prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Decoded from flops only, so the pulse is glitch-free.
    assign btn_rise = sync2_q & ~prev_q;

endmodule

// File: rtl/game_controller.sv
// Game sequencer: idle/play/dead/over FSM, tick counter, hit latch and high score.
// Define HIGH_SCORE_EN to build the high-score tracker; otherwise high_score_o is 0.
module game_controller
    import game_pkg::*;
#(
    parameter logic [9:0] FLOOR_Y    = 10'd440,
    parameter logic [9:0] CEIL_Y     = 10'd40,
    parameter logic [7:0] DEAD_TICKS = 8'd60,
    parameter logic [7:0] LOCK_TICKS = 8'd30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick_i,
    input  logic       btn_pressed_i,
    input  logic       collision_i,
    input  logic [9:0] bird_y_i,
    input  logic [6:0] score_i,
    output logic       run_o,
    output logic       reset_score_o,
    output logic       reset_physics_o,
    output logic [1:0] state_o,
    output logic       flash_o,
    output logic [6:0] high_score_o
);

    game_state_e state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        hit_q, hit_d;
    logic        run_q, run_d;
    logic        rst_score_q, rst_score_d;
    logic        rst_phys_q, rst_phys_d;
    logic        flash_q, flash_d;
    logic        btn_rise;

    btn_sync u_btn_sync (
        .clk      (clk),
        .rst      (rst),
        .btn_in   (btn_pressed_i),
        .btn_rise (btn_rise)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hit_d   = hit_q;
        unique case (state_q)
            ST_IDLE: begin
                if (btn_rise) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                hit_d = hit_q | collision_i;
                // Death wins over any concurrent button press.
                if (hit_q || collision_i || (bird_y_i >= FLOOR_Y) || (bird_y_i < CEIL_Y)) begin
                    state_d = ST_DEAD;
                end
            end
            ST_DEAD: begin
                if (frame_tick_i) begin
                    if (cnt_q == DEAD_TICKS - 8'd1) state_d = ST_OVER;
                    else                            cnt_d   = cnt_q + 8'd1;
                end
            end
            ST_OVER: begin
                if (btn_rise && (cnt_q == LOCK_TICKS)) begin
                    state_d = ST_IDLE;
                end else if (frame_tick_i && (cnt_q < LOCK_TICKS)) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d != state_q) cnt_d = 8'd0;
        if ((state_d == ST_PLAY) && (state_q != ST_PLAY)) hit_d = 1'b0;

        run_d       = (state_d == ST_PLAY);
        rst_score_d = (state_d == ST_IDLE);
        rst_phys_d  = (state_d == ST_IDLE);

        // Toggle each time the dead counter completes a group of 8 ticks.
        flash_d = 1'b0;
        if ((state_d == ST_DEAD) && (state_q == ST_DEAD)) begin
            flash_d = flash_q ^ (frame_tick_i && (cnt_q[2:0] == 3'd7));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            hit_q       <= 1'b0;
            run_q       <= 1'b0;
            rst_score_q <= 1'b1;
            rst_phys_q  <= 1'b1;
            flash_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hit_q       <= hit_d;
            run_q       <= run_d;
            rst_score_q <= rst_score_d;
            rst_phys_q  <= rst_phys_d;
            flash_q     <= flash_d;
        end
    end

`ifdef HIGH_SCORE_EN
    logic [6:0] high_score_q, high_score_d;

    always_comb begin
        high_score_d = high_score_q;
        if ((state_q == ST_PLAY) && (state_d == ST_DEAD) && (score_i > high_score_q)) begin
            high_score_d = score_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) high_score_q <= 7'd0;
        else     high_score_q <= high_score_d;
    end

    assign high_score_o = high_score_q;
`else
    logic unused_score;
    assign unused_score = ^score_i;
    assign high_score_o = 7'd0;
`endif

    assign run_o           = run_q;
    assign reset_score_o   = rst_score_q;
    assign reset_physics_o = rst_phys_q;
    assign state_o         = state_q;
    assign flash_o         = flash_q;

endmodule

// File: tb/tb_game_controller.sv
// Directed-vector bench for game_controller (DEAD_TICKS=4, LOCK_TICKS=2).
module tb_game_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_tick;
    logic       btn_pressed;
    logic       collision;
    logic [9:0] bird_y;
    logic [6:0] score;
    logic       run, reset_score, reset_physics, flash;
    logic [1:0] state;
    logic [6:0] high_score;

    int n_vec = 0;
    int n_err = 0;

`ifdef HIGH_SCORE_EN
    localparam bit HsEn = 1'b1;
`else
    localparam bit HsEn = 1'b0;
`endif

    game_controller #(
        .FLOOR_Y    (10'd440),
        .CEIL_Y     (10'd40),
        .DEAD_TICKS (8'd4),
        .LOCK_TICKS (8'd2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .frame_tick_i    (frame_tick),
        .btn_pressed_i   (btn_pressed),
        .collision_i     (collision),
        .bird_y_i        (bird_y),
        .score_i         (score),
        .run_o           (run),
        .reset_score_o   (reset_score),
        .reset_physics_o (reset_physics),
        .state_o         (state),
        .flash_o         (flash),
        .high_score_o    (high_score)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n clocks; inputs and samples sit 1 time unit after the edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            step(1);
            frame_tick = 1'b0;
        end
    endtask

    task automatic press();
        btn_pressed = 1'b1;
        step(3);
        btn_pressed = 1'b0;
        step(3);
    endtask

    initial begin
        rst = 1'b1;
        frame_tick = 1'b0;
        btn_pressed = 1'b0;
        collision = 1'b0;
        bird_y = 10'd200;
        score = 7'd0;
        step(3);
        check("rst_state", state, 0);
        check("rst_run", run, 0);
        check("rst_rscore", reset_score, 1);
        check("rst_rphys", reset_physics, 1);
        check("rst_hs", high_score, 0);
        check("rst_flash", flash, 0);
        rst = 1'b0;
        step(2);
        check("idle_hold", state, 0);

        // Button to play: exactly three clocks of latency.
        btn_pressed = 1'b1;
        step(2);
        check("start_lat2", state, 0);
        step(1);
        check("start_state", state, 1);
        check("start_run", run, 1);
        check("start_rscore", reset_score, 0);
        check("start_rphys", reset_physics, 0);
        btn_pressed = 1'b0;
        step(3);

        // Ceiling/floor boundaries are not hits.
        bird_y = 10'd40;
        step(1);
        check("ceil_edge", state, 1);
        bird_y = 10'd439;
        step(1);
        check("floor_edge", state, 1);
        bird_y = 10'd200;
        press();
        check("play_btn", state, 1);

        // One-clock collision pulse kills.
        score = 7'd5;
        collision = 1'b1;
        step(1);
        collision = 1'b0;
        check("coll_state", state, 2);
        check("coll_run", run, 0);
        check("coll_rphys", reset_physics, 0);
        press();
        check("dead_btn", state, 2);
        tick(3);
        check("dead_3tick", state, 2);
        check("dead_flash", flash, 0);
        tick(1);
        check("dead_4tick", state, 3);
        check("over_run", run, 0);
        check("hs_after5", high_score, HsEn ? 5 : 0);

        // Lockout: early press dropped, counter saturates at LOCK_TICKS.
        tick(1);
        press();
        check("over_early", state, 3);
        tick(3);
        btn_pressed = 1'b1;
        step(3);
        check("over_exit", state, 0);
        check("over_rscore", reset_score, 1);
        check("over_rphys", reset_physics, 1);
        btn_pressed = 1'b0;
        step(3);

        // Game 2: floor hit together with a button rise.
        press();
        check("g2_state", state, 1);
        score = 7'd3;
        btn_pressed = 1'b1;
        step(2);
        bird_y = 10'd470;
        step(1);
        check("floor_vs_btn", state, 2);
        btn_pressed = 1'b0;
        bird_y = 10'd200;
        step(1);
        check("hs_after3", high_score, HsEn ? 5 : 0);
        tick(4);
        tick(2);
        press();
        check("g2_idle", state, 0);

        // Game 3: ceiling hit with a new best score.
        press();
        check("g3_state", state, 1);
        score = 7'd9;
        bird_y = 10'd30;
        step(1);
        check("ceil_state", state, 2);
        step(1);
        check("hs_after9", high_score, HsEn ? 9 : 0);
        bird_y = 10'd200;
        tick(4);
        tick(2);
        press();

        // Game 4: underflowed bird_y, then asynchronous reset mid-play.
        press();
        bird_y = 10'd1023;
        step(1);
        check("underflow", state, 2);
        bird_y = 10'd200;
        #2 rst = 1'b1;
        #1;
        check("async_state", state, 0);
        check("async_rscore", reset_score, 1);
        check("async_hs", high_score, 0);
        rst = 1'b0;
        step(2);
        check("post_rst", state, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
